// File: rtl/fetch_ctrl_if.sv
// Bundles the L1 request/response, ID-stage control and instr_reg feed signals
// of the fetch sequencer; slave is the sequencer's view, master the environment's.
interface fetch_ctrl_if #(
    parameter int n     = 32,
    parameter int CNT_W = 16
);
    logic             L1_busy;
    logic [n-1:0]     L1_rdata;
    logic             L1_read;
    logic [n-1:0]     L1_addr;
    logic             stall_id;
    logic             branch_taken;
    logic [n-1:0]     branch_target;
    logic [n-1:0]     instruction_next;
    logic [n-1:0]     pc_next;
    logic [n-1:0]     pc_plus_four_next;
    logic             ir_write;
    logic             ir_flush;
    logic [CNT_W-1:0] miss_count;

    modport slave (
        input  L1_busy, L1_rdata, stall_id, branch_taken, branch_target,
        output L1_read, L1_addr, instruction_next, pc_next, pc_plus_four_next,
               ir_write, ir_flush, miss_count
    );

    modport master (
        output L1_busy, L1_rdata, stall_id, branch_taken, branch_target,
        input  L1_read, L1_addr, instruction_next, pc_next, pc_plus_four_next,
               ir_write, ir_flush, miss_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives L1 reads, absorbs miss and
// ID stalls, and handles branch redirects including ones landing mid-miss.
module fetch_ctrl #(
    parameter int         n        = 32,
    parameter logic [n-1:0] RESET_PC = '0,
    parameter int         CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [n-1:0]     pc_q, pc_d;
    logic [n-1:0]     missAddr_q, missAddr_d;
    logic [n-1:0]     holdInstr_q, holdInstr_d;
    logic [n-1:0]     holdPc_q, holdPc_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] missCount_q, missCount_d;

    logic             l1Read;
    logic [n-1:0]     l1Addr;
    logic [n-1:0]     instrNext;
    logic [n-1:0]     pcNext;
    logic [n-1:0]     pcPlus4Next;
    logic             irWrite;
    logic             irFlush;
    logic [n-1:0]     branchTarget;

    assign branchTarget = {bus.branch_target[n-1:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            missAddr_q  <= RESET_PC;
            holdInstr_q <= '0;
            holdPc_q    <= '0;
            discard_q   <= 1'b0;
            missCount_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            missAddr_q  <= missAddr_d;
            holdInstr_q <= holdInstr_d;
            holdPc_q    <= holdPc_d;
            discard_q   <= discard_d;
            missCount_q <= missCount_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        missAddr_d  = missAddr_q;
        holdInstr_d = holdInstr_q;
        holdPc_d    = holdPc_q;
        discard_d   = discard_q;
        missCount_d = missCount_q;
        l1Read      = 1'b0;
        l1Addr      = pc_q;
        instrNext   = '0;
        pcNext      = '0;
        pcPlus4Next = '0;
        irWrite     = 1'b0;
        irFlush     = 1'b0;

        case (state_q)
            S_FETCH: begin
                l1Read      = 1'b1;
                l1Addr      = pc_q;
                instrNext   = bus.L1_rdata;
                pcNext      = pc_q;
                pcPlus4Next = pc_q + n'(4);
                // A redirect still has to ride out a miss in flight, so the
                // returning data is marked for discard rather than counted.
                if (bus.branch_taken) begin
                    irFlush = 1'b1;
                    pc_d    = branchTarget;
                    if (bus.L1_busy) begin
                        state_d    = S_WAIT;
                        discard_d  = 1'b1;
                        missAddr_d = pc_q;
                    end
                end else if (bus.L1_busy) begin
                    state_d    = S_WAIT;
                    missAddr_d = pc_q;
                    if (missCount_q != '1) missCount_d = missCount_q + CNT_W'(1);
                end else if (bus.stall_id) begin
                    state_d     = S_HOLD;
                    holdInstr_d = bus.L1_rdata;
                    holdPc_d    = pc_q;
                end else begin
                    irWrite = 1'b1;
                    pc_d    = pc_q + n'(4);
                end
            end

            S_WAIT: begin
                l1Read      = 1'b1;
                l1Addr      = missAddr_q;
                instrNext   = bus.L1_rdata;
                pcNext      = missAddr_q;
                pcPlus4Next = missAddr_q + n'(4);
                if (bus.branch_taken) begin
                    irFlush   = 1'b1;
                    pc_d      = branchTarget;
                    discard_d = 1'b1;
                end
                if (!bus.L1_busy) begin
                    if (discard_q || bus.branch_taken) begin
                        state_d   = S_FETCH;
                        discard_d = 1'b0;
                    end else if (bus.stall_id) begin
                        state_d     = S_HOLD;
                        holdInstr_d = bus.L1_rdata;
                        holdPc_d    = missAddr_q;
                    end else begin
                        state_d = S_FETCH;
                        irWrite = 1'b1;
                        pc_d    = missAddr_q + n'(4);
                    end
                end
            end

            S_HOLD: begin
                l1Addr      = pc_q;
                instrNext   = holdInstr_q;
                pcNext      = holdPc_q;
                pcPlus4Next = holdPc_q + n'(4);
                if (bus.branch_taken) begin
                    irFlush = 1'b1;
                    pc_d    = branchTarget;
                    state_d = S_FETCH;
                end else if (!bus.stall_id) begin
                    irWrite = 1'b1;
                    pc_d    = holdPc_q + n'(4);
                    state_d = S_FETCH;
                end
            end

            default: state_d = S_FETCH;
        endcase
    end

    // Every output is forced low for as long as reset is held.
    assign bus.L1_read           = l1Read & ~reset;
    assign bus.L1_addr           = reset ? '0 : l1Addr;
    assign bus.instruction_next  = reset ? '0 : instrNext;
    assign bus.pc_next           = reset ? '0 : pcNext;
    assign bus.pc_plus_four_next = reset ? '0 : pcPlus4Next;
    assign bus.ir_write          = irWrite & ~reset;
    assign bus.ir_flush          = irFlush & ~reset;
    assign bus.miss_count        = reset ? '0 : missCount_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl, checked every cycle against a behavioural
// model of the fetch rules; uses a 4-bit miss counter so saturation is reached.
module tb_fetch_ctrl;

   localparam int CNT_W   = 4;
   localparam int CYCLES  = 3000;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   bit   clockRun = 1'b0;

   int compareCount = 0;
   int mismatchCount = 0;

   fetch_ctrl_if #(.n(32), .CNT_W(CNT_W)) bus ();

   fetch_ctrl #(.n(32), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running clock that can be parked low for the stopped-clock reset test
   always #5 if (clockRun) clk = ~clk;

   // Model state: what the fetcher is doing, expressed as pending conditions
   logic [31:0] mPc, mMissAddr, mHeldInstr, mHeldPc;
   bit          mMissPending, mDropData, mHolding;
   int          mMisses;

   logic [31:0] nPc, nMissAddr, nHeldInstr, nHeldPc;
   bit          nMissPending, nDropData, nHolding;
   int          nMisses;

   logic [31:0] expAddr, expInstr, expPc, expPc4;
   bit          expRead, expWrite, expFlush;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
      end
   endtask

   task automatic modelReset();
      mPc = 32'h0; mMissAddr = 32'h0; mHeldInstr = 32'h0; mHeldPc = 32'h0;
      mMissPending = 0; mDropData = 0; mHolding = 0; mMisses = 0;
   endtask

   // Delivers an instruction: either to instr_reg now, or into the hold slot
   task automatic deliver(input logic [31:0] instr, input logic [31:0] addr);
      if (bus.stall_id) begin
         nHolding = 1; nHeldInstr = instr; nHeldPc = addr;
      end else begin
         expWrite = 1; nPc = addr + 32'd4;
      end
   endtask

   task automatic modelCycle();
      logic [31:0] tgt;
      tgt = bus.branch_target & 32'hFFFF_FFFC;
      nPc = mPc; nMissAddr = mMissAddr; nHeldInstr = mHeldInstr; nHeldPc = mHeldPc;
      nMissPending = mMissPending; nDropData = mDropData; nHolding = mHolding; nMisses = mMisses;
      expWrite = 0; expFlush = 0;
      if (mHolding) begin
         expRead = 0; expAddr = mPc; expInstr = mHeldInstr; expPc = mHeldPc; expPc4 = mHeldPc + 32'd4;
         if (bus.branch_taken) begin
            expFlush = 1; nPc = tgt; nHolding = 0;
         end else if (!bus.stall_id) begin
            expWrite = 1; nPc = mHeldPc + 32'd4; nHolding = 0;
         end
      end else if (mMissPending) begin
         expRead = 1; expAddr = mMissAddr; expInstr = bus.L1_rdata; expPc = mMissAddr; expPc4 = mMissAddr + 32'd4;
         if (bus.branch_taken) begin
            expFlush = 1; nPc = tgt; nDropData = 1;
         end
         if (!bus.L1_busy) begin
            nMissPending = 0;
            if (mDropData || bus.branch_taken) nDropData = 0;
            else deliver(bus.L1_rdata, mMissAddr);
         end
      end else begin
         expRead = 1; expAddr = mPc; expInstr = bus.L1_rdata; expPc = mPc; expPc4 = mPc + 32'd4;
         if (bus.branch_taken) begin
            expFlush = 1; nPc = tgt;
            if (bus.L1_busy) begin
               nMissPending = 1; nDropData = 1; nMissAddr = mPc;
            end
         end else if (bus.L1_busy) begin
            nMissPending = 1; nMissAddr = mPc;
            if (mMisses < CNT_MAX) nMisses = mMisses + 1;
         end else begin
            deliver(bus.L1_rdata, mPc);
         end
      end
   endtask

   task automatic modelCommit();
      mPc = nPc; mMissAddr = nMissAddr; mHeldInstr = nHeldInstr; mHeldPc = nHeldPc;
      mMissPending = nMissPending; mDropData = nDropData; mHolding = nHolding; mMisses = nMisses;
   endtask

   task automatic checkAllZero();
      checkOutput("rst_L1_read", 32'(bus.L1_read), 32'h0);
      checkOutput("rst_L1_addr", bus.L1_addr, 32'h0);
      checkOutput("rst_instr", bus.instruction_next, 32'h0);
      checkOutput("rst_pc_next", bus.pc_next, 32'h0);
      checkOutput("rst_pc4", bus.pc_plus_four_next, 32'h0);
      checkOutput("rst_ir_write", 32'(bus.ir_write), 32'h0);
      checkOutput("rst_ir_flush", 32'(bus.ir_flush), 32'h0);
      checkOutput("rst_miss_count", 32'(bus.miss_count), 32'h0);
   endtask

   task automatic checkAgainstModel();
      checkOutput("L1_read", 32'(bus.L1_read), 32'(expRead));
      checkOutput("L1_addr", bus.L1_addr, expAddr);
      checkOutput("ir_write", 32'(bus.ir_write), 32'(expWrite));
      checkOutput("ir_flush", 32'(bus.ir_flush), 32'(expFlush));
      checkOutput("miss_count", 32'(bus.miss_count), 32'(mMisses));
      if (expRead || mHolding) begin
         checkOutput("instruction_next", bus.instruction_next, expInstr);
         checkOutput("pc_next", bus.pc_next, expPc);
         checkOutput("pc_plus_four_next", bus.pc_plus_four_next, expPc4);
      end
   endtask

   // Random inputs, with branch targets steered near the top of memory at times
   task automatic applyStimulus();
      int pick;
      bus.L1_busy      = ($urandom_range(0, 99) < 30);
      bus.stall_id     = ($urandom_range(0, 99) < 20);
      bus.branch_taken = ($urandom_range(0, 99) < 8);
      bus.L1_rdata     = $urandom;
      pick = $urandom_range(0, 3);
      case (pick)
         0:       bus.branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         1:       bus.branch_target = $urandom;
         default: bus.branch_target = 32'($urandom_range(0, 4095));
      endcase
   endtask

   initial begin
      bus.L1_busy = 0; bus.L1_rdata = 0; bus.stall_id = 0;
      bus.branch_taken = 0; bus.branch_target = 0;

      // Reset with the clock parked
      #2;
      checkAllZero();
      #6 reset = 1'b0;
      modelReset();
      #4 clockRun = 1'b1;

      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         if (cyc > 20 && $urandom_range(0, 249) == 0) begin
            reset = 1'b1;
            #1;
            checkAllZero();
            modelReset();
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            continue;
         end
         applyStimulus();
         #1;
         modelCycle();
         checkAgainstModel();
         @(posedge clk);
         modelCommit();
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for one core.
- Issues read requests to the L1 instruction cache and absorbs L1_busy miss stalls.
- Owns the PC and produces the instruction_next / pc_next / pc_plus_four_next inputs, plus load-enable and flush, for the IF/ID instruction register (instr_reg).
- Also handles downstream ID stalls and taken-branch redirects, including a redirect that arrives while a miss is outstanding.

Parameters:
- n, 32, datapath width of addresses and instructions.
- RESET_PC, 0, PC loaded on reset. Must be 4-byte aligned.
- CNT_W, 16, width of the saturating miss counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- L1_busy  in  1  L1 is servicing a miss; the read data is not yet valid.
- L1_rdata  in  n  L1 read data. Valid in any cycle with L1_read=1 and L1_busy=0.
- L1_read  out  1  read request to L1.
- L1_addr  out  n  fetch address to L1.
- stall_id  in  1  ID stage cannot accept a new instruction this cycle.
- branch_taken  in  1  one-cycle redirect request.
- branch_target  in  n  redirect address. Bits [1:0] are ignored and forced to 0.
- instruction_next  out  n  instruction presented to instr_reg.
- pc_next  out  n  PC of the presented instruction.
- pc_plus_four_next  out  n  pc_next + 4, modulo 2^n.
- ir_write  out  1  instr_reg load enable.
- ir_flush  out  1  instr_reg bubble insert.
- miss_count  out  CNT_W  number of L1 misses, saturating.

Behaviour:

Reset:
- While reset=1: state=FETCH, pc=RESET_PC, hold buffer=0, discard=0, miss_count=0.
- All outputs are 0 while reset=1; L1_read is gated low combinationally.
- Reset asserted mid-miss abandons the miss; the L1 must tolerate L1_read dropping.

State FETCH:
- L1_read=1, L1_addr=pc.
- Outputs are driven combinationally: instruction_next=L1_rdata, pc_next=pc, pc_plus_four_next=pc+4.
- Cycle resolution, first match wins:
  1. branch_taken=1: ir_write=0, ir_flush=1; pc<=target; L1_rdata is dropped. If L1_busy=1, go to WAIT with discard=1; otherwise stay in FETCH.
  2. L1_busy=1: ir_write=0; miss_count+=1 (saturating); go to WAIT.
  3. stall_id=1: ir_write=0; capture {L1_rdata, pc} into the hold buffer; go to HOLD.
  4. Otherwise: ir_write=1; pc<=pc+4; stay in FETCH. Hit throughput is one instruction per cycle.

State WAIT:
- L1_read=1; L1_addr stays at the address that missed, even when discard=1 (the old pc is kept in a miss-address register).
- ir_write=0.
- If branch_taken=1: ir_flush=1, pc<=target, discard<=1. A later branch overwrites the target.
- When L1_busy falls:
  - discard=1: drop the data, clear discard, go to FETCH at the new pc. No ir_write that cycle.
  - discard=0: resolve exactly as FETCH rules 3 and 4, using the miss address as pc_next.
- miss_count does not increment again for the same miss.

State HOLD:
- L1_read=0.
- Outputs come from the hold buffer; pc_plus_four_next = held pc + 4.
- stall_id=1: ir_write=0, values held stable.
- stall_id=0: ir_write=1; pc<=held pc + 4; go to FETCH.
- branch_taken=1 (wins over a release): ir_flush=1, buffer discarded, pc<=target, go to FETCH.

General rules:
- ir_write and ir_flush are never both 1 in the same cycle.
- ir_flush is a one-cycle pulse per branch_taken cycle.
- PC wrap-around: 0xFFFFFFFC + 4 = 0x00000000, with no error.
- miss_count holds at 2^CNT_W - 1 once saturated.

Test Plan:
1. Reset: pulse reset with clk stopped, then release -> all outputs 0 during reset. First cycle after release: L1_read=1, L1_addr=0x0, miss_count=0.
2. Hit stream: L1_busy=0, L1_rdata=55 -> ir_write=1, instruction_next=55, pc_next=0, pc_plus_four_next=4. Next cycle L1_addr=4; L1_addr=8 after two hits.
3. Miss: L1_busy=1 for 2 cycles at pc=8, then L1_rdata=0x1234 -> L1_addr held at 8, ir_write=0 for 2 cycles, miss_count=1. Third cycle: ir_write=1, pc_next=8, pc_plus_four_next=12.
4. ID stall: hit at pc=12 with stall_id=1 for 3 cycles -> L1_read=0 and ir_write=0 for 3 cycles, outputs stable at pc_next=12. Release: ir_write=1 with the same values, then L1_addr=16.
5. Branch during miss: at pc=16, L1_busy=1 for 3 cycles; branch_taken=1 with target 0x103 in the 2nd cycle -> ir_flush=1 for one cycle, L1_addr stays 16. When busy falls, the data is dropped with ir_write=0; next L1_addr=0x100.
6. Simultaneous events: branch_taken=1 (target 0x200) on a hit with stall_id=0 -> ir_write=0, ir_flush=1, next L1_addr=0x200. Separately, pc=0xFFFFFFFC hit -> pc_plus_four_next=0, next L1_addr=0.
